riscv_exc_responder: RTL and testbench
======================================

// Module: riscv_exc_responder
// PURPOSE
// - Responder side of the exception req/ack handshake; sits in the ID-stage control path.
// - Accepts exc_req_i and waits for outstanding LSU data traffic to drain, bounded by a timeout.
// - Then acks, redirects fetch and pulses EPC save.
// - Also sequences boot PC set, eret return and debug halt/resume.
// PARAMETERS
// DRAIN_TIMEOUT  16  max cycles spent in DRAIN before ack is forced (>=1)
// CNT_W          16  width of exc_cnt_o (only with RISCV_EXC_CNT_EN)
// PORTS
// clk               in   1   clock, rising edge
// rst_n             in   1   asynchronous active-low reset
// fetch_enable_i    in   1   core may leave boot
// exc_req_i         in   1   exception/irq request; held high until acked
// exc_ack_o         out  1   request accepted (combinational, same cycle allowed)
// eret_insn_i       in   1   eret decoded in ID
// id_valid_i        in   1   ID holds a valid instruction
// data_req_pending_i in  1   LSU has an outstanding data transaction
// dbg_halt_i        in   1   debug unit requests halt
// dbg_resume_i      in   1   debug unit releases halt
// pc_set_o          out  1   one-cycle PC redirect strobe
// pc_mux_o          out  2   00 PC_BOOT, 01 PC_EXCEPTION, 10 PC_ERET, 11 reserved
// halt_if_o         out  1   stall IF
// halt_id_o         out  1   stall ID
// save_epc_o        out  1   CSR captures EPC/cause (coincides with exc_ack_o)
// csr_restore_o     out  1   CSR restores status on eret
// drain_timeout_o   out  1   sticky: a drain ended by timeout
// exc_cnt_o         out  CNT_W  exceptions acknowledged (RISCV_EXC_CNT_EN only)
// BEHAVIOUR
// - States: BOOT, RUN, DRAIN, DBG_HALT; state register async-reset to BOOT.
// - Reset values:
//   - exc_ack_o, pc_set_o, save_epc_o, csr_restore_o, drain_timeout_o = 0.
//   - pc_mux_o = 00; halt_if_o = halt_id_o = 1; drain counter = 0.
// - Strobes exc_ack_o, pc_set_o, save_epc_o, csr_restore_o are 0 unless stated below.
// - BOOT: halt_if/id = 1.
//   - fetch_enable_i=1 -> pc_set_o=1, pc_mux_o=00, next RUN.
// - RUN: halt_if/id = 0. Priority: exc_req_i > dbg_halt_i > eret.
//   - exc_req_i & !data_req_pending_i -> same-cycle exc_ack_o=save_epc_o=pc_set_o=1, pc_mux_o=01; stay RUN.
//   - exc_req_i & data_req_pending_i -> halt_if/id=1 this cycle; counter<=0; next DRAIN.
//   - else dbg_halt_i -> halt_if/id=1; next DBG_HALT.
//   - else eret_insn_i & id_valid_i -> pc_set_o=csr_restore_o=1, pc_mux_o=10.
// - DRAIN: halt_if/id = 1; counter increments each cycle.
//   - Exit when !data_req_pending_i OR counter==DRAIN_TIMEOUT-1.
//   - On exit: exc_ack_o=save_epc_o=pc_set_o=1, pc_mux_o=01; next RUN.
//   - Exit by timeout while still pending -> drain_timeout_o<=1 (sticky until reset).
//   - dbg_halt_i ignored in DRAIN; it is served from RUN afterwards.
// - DBG_HALT: halt_if/id = 1.
//   - dbg_resume_i -> next RUN; no pc_set.
//   - exc_req_i is not acked while halted.
// - Latency:
//   - exc_req_i with no pending LSU traffic: ack in 0 cycles.
//   - Otherwise ack <= DRAIN_TIMEOUT cycles after entering DRAIN.
// - exc_req_i falling before ack in DRAIN is a protocol violation; sim assertion fires (non-synth).
// - Reset mid-DRAIN: counter and state reset at once; no ack is issued.
// CONFIGURATION
// - RISCV_EXC_CNT_EN defined:
//   - exc_cnt_o increments on every exc_ack_o, saturating at all-ones; resets to 0.
// - RISCV_EXC_CNT_EN undefined:
//   - exc_cnt_o port absent; no counter logic.
// TESTING
// - Reset release, fetch_enable_i=1 at cycle 3 -> single pc_set_o pulse with pc_mux_o=00; halt_if_o=0 next cycle.
// - RUN, exc_req_i=1, pending=0 -> same cycle exc_ack_o=save_epc_o=pc_set_o=1, pc_mux_o=01.
// - exc_req_i=1, pending=1 for 3 cycles -> halt_if/id=1; ack on DRAIN cycle 4; drain_timeout_o=0.
// - Pending held high, DRAIN_TIMEOUT=16 -> ack on 16th DRAIN cycle; drain_timeout_o=1 and stays 1.
// - exc_req_i, eret_insn_i, id_valid_i high together -> exception wins: pc_mux_o=01, csr_restore_o=0.
// - RISCV_EXC_CNT_EN, CNT_W=2, 5 acks -> exc_cnt_o=3.
//   - Reset asserted mid-DRAIN -> all outputs return to reset values, no ack.

Source files
------------

// File: rtl/riscv_exc_responder_if.sv
// Exception responder bus: exception req/ack, LSU drain status, debug halt/resume and
// the PC-redirect / pipeline-stall controls driven back into IF/ID.
interface riscv_exc_responder_if;
  logic       fetch_enable_i;
  logic       exc_req_i;
  logic       exc_ack_o;
  logic       eret_insn_i;
  logic       id_valid_i;
  logic       data_req_pending_i;
  logic       dbg_halt_i;
  logic       dbg_resume_i;
  logic       pc_set_o;
  logic [1:0] pc_mux_o;
  logic       halt_if_o;
  logic       halt_id_o;
  logic       save_epc_o;
  logic       csr_restore_o;
  logic       drain_timeout_o;

  // The responder (this block) sees the _i signals as inputs.
  modport slave (
    input  fetch_enable_i, exc_req_i, eret_insn_i, id_valid_i,
           data_req_pending_i, dbg_halt_i, dbg_resume_i,
    output exc_ack_o, pc_set_o, pc_mux_o, halt_if_o, halt_id_o,
           save_epc_o, csr_restore_o, drain_timeout_o
  );

  modport master (
    output fetch_enable_i, exc_req_i, eret_insn_i, id_valid_i,
           data_req_pending_i, dbg_halt_i, dbg_resume_i,
    input  exc_ack_o, pc_set_o, pc_mux_o, halt_if_o, halt_id_o,
           save_epc_o, csr_restore_o, drain_timeout_o
  );
endinterface

// File: rtl/riscv_exc_responder.sv
// Exception req/ack responder: boot PC set, LSU drain with timeout, eret and debug halt.
// Optional feature: RISCV_EXC_CNT_EN adds the saturating exc_cnt_o acknowledge counter.
module riscv_exc_responder #(
  parameter int DRAIN_TIMEOUT = 16
`ifdef RISCV_EXC_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  riscv_exc_responder_if.slave       bus
`ifdef RISCV_EXC_CNT_EN
  , output logic [CNT_W-1:0]         exc_cnt_o
`endif
);

  localparam int CW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);

  localparam logic [1:0] PC_BOOT      = 2'b00;
  localparam logic [1:0] PC_EXCEPTION = 2'b01;
  localparam logic [1:0] PC_ERET      = 2'b10;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN, S_DBG_HALT} state_e;

  state_e        r_state;
  state_e        w_next;
  logic [CW-1:0] r_drain_cnt;
  logic          r_drain_timeout;
  logic          w_ack;
  logic          w_pc_set;
  logic [1:0]    w_pc_mux;
  logic          w_halt;
  logic          w_csr_restore;
  logic          w_drain_last;

  assign w_drain_last = (r_drain_cnt == DRAIN_LAST);

  // Outputs are Mealy: the ack and the RUN-state stall must appear in the request cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_next        = r_state;
    w_ack         = 1'b0;
    w_pc_set      = 1'b0;
    w_pc_mux      = PC_BOOT;
    w_halt        = 1'b1;
    w_csr_restore = 1'b0;
    unique case (r_state)
      S_BOOT: begin
        if (bus.fetch_enable_i) begin
          w_pc_set = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        w_halt = 1'b0;
        if (bus.exc_req_i) begin
          if (!bus.data_req_pending_i) begin
            w_ack    = 1'b1;
            w_pc_set = 1'b1;
            w_pc_mux = PC_EXCEPTION;
          end else begin
            w_halt = 1'b1;
            w_next = S_DRAIN;
          end
        end else if (bus.dbg_halt_i) begin
          w_halt = 1'b1;
          w_next = S_DBG_HALT;
        end else if (bus.eret_insn_i && bus.id_valid_i) begin
          w_pc_set      = 1'b1;
          w_csr_restore = 1'b1;
          w_pc_mux      = PC_ERET;
        end
      end
      S_DRAIN: begin
        if (!bus.data_req_pending_i || w_drain_last) begin
          w_ack    = 1'b1;
          w_pc_set = 1'b1;
          w_pc_mux = PC_EXCEPTION;
          w_next   = S_RUN;
        end
      end
      S_DBG_HALT: begin
        if (bus.dbg_resume_i) w_next = S_RUN;
      end
      default: w_next = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_BOOT;
      r_drain_cnt     <= '0;
      r_drain_timeout <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Counter is zero on the first DRAIN cycle because it is cleared in every other state.
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
      if (r_state == S_DRAIN && bus.data_req_pending_i && w_drain_last)
        r_drain_timeout <= 1'b1;
    end
  end

  assign bus.exc_ack_o       = w_ack;
  assign bus.save_epc_o      = w_ack;
  assign bus.pc_set_o        = w_pc_set;
  assign bus.pc_mux_o        = w_pc_mux;
  assign bus.halt_if_o       = w_halt;
  assign bus.halt_id_o       = w_halt;
  assign bus.csr_restore_o   = w_csr_restore;
  assign bus.drain_timeout_o = r_drain_timeout;

`ifdef RISCV_EXC_CNT_EN
  logic [CNT_W-1:0] r_exc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_exc_cnt <= '0;
    else if (w_ack && r_exc_cnt != '1) r_exc_cnt <= r_exc_cnt + 1'b1;
  end

  assign exc_cnt_o = r_exc_cnt;
`endif

`ifndef SYNTHESIS
  // The requester must hold exc_req_i until it is acknowledged.
  a_req_held_in_drain : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_DRAIN) |-> bus.exc_req_i)
    else $error("exc_req_i dropped before acknowledge during DRAIN");
`endif

endmodule

// File: tb/tb_riscv_exc_responder.sv
// Directed bench for riscv_exc_responder; define RISCV_EXC_CNT_EN to also cover exc_cnt_o.
module tb_riscv_exc_responder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  riscv_exc_responder_if bus ();

`ifdef RISCV_EXC_CNT_EN
  logic [1:0] exc_cnt;
  riscv_exc_responder #(.DRAIN_TIMEOUT(16), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .exc_cnt_o(exc_cnt));
`else
  riscv_exc_responder #(.DRAIN_TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       exc_req;
    logic       pending;
    logic       eret;
    logic       id_valid;
    logic       dbg_halt;
    logic       ack;
    logic       pc_set;
    logic [1:0] mux;
    logic       halt;
    logic       restore;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.exc_req_i          = 1'b0;
    bus.eret_insn_i        = 1'b0;
    bus.id_valid_i         = 1'b0;
    bus.data_req_pending_i = 1'b0;
    bus.dbg_halt_i         = 1'b0;
    bus.dbg_resume_i       = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"},     32'(bus.exc_ack_o),       32'd0);
    check({tag, "_pc_set"},  32'(bus.pc_set_o),        32'd0);
    check({tag, "_mux"},     32'(bus.pc_mux_o),        32'd0);
    check({tag, "_halt_if"}, 32'(bus.halt_if_o),       32'd1);
    check({tag, "_halt_id"}, 32'(bus.halt_id_o),       32'd1);
    check({tag, "_save"},    32'(bus.save_epc_o),      32'd0);
    check({tag, "_restore"}, 32'(bus.csr_restore_o),   32'd0);
    check({tag, "_timeout"}, 32'(bus.drain_timeout_o), 32'd0);
  endtask

  // Boot from reset: fetch enable raised on the third cycle after release.
  task automatic boot(input string tag);
    rst_n = 1'b1;
    tick();
    tick();
    bus.fetch_enable_i = 1'b1;
    #2;
    check({tag, "_boot_pc_set"}, 32'(bus.pc_set_o), 32'd1);
    check({tag, "_boot_mux"},    32'(bus.pc_mux_o), 32'd0);
    tick();
    #2;
    check({tag, "_run_halt_if"}, 32'(bus.halt_if_o), 32'd0);
    check({tag, "_run_pc_set"},  32'(bus.pc_set_o),  32'd0);
    tick();
  endtask

  vec_t vecs[7];
  int   ack_cyc;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.fetch_enable_i = 1'b0;
    idle_inputs();

    vecs[0] = '{"idle",          0, 0, 0, 0, 0,  0, 0, 2'b00, 0, 0};
    vecs[1] = '{"exc_nopend",    1, 0, 0, 0, 0,  1, 1, 2'b01, 0, 0};
    vecs[2] = '{"eret_valid",    0, 0, 1, 1, 0,  0, 1, 2'b10, 0, 1};
    vecs[3] = '{"eret_invalid",  0, 0, 1, 0, 0,  0, 0, 2'b00, 0, 0};
    vecs[4] = '{"exc_over_eret", 1, 0, 1, 1, 0,  1, 1, 2'b01, 0, 0};
    vecs[5] = '{"exc_over_dbg",  1, 0, 0, 0, 1,  1, 1, 2'b01, 0, 0};
    vecs[6] = '{"pend_only",     0, 1, 0, 1, 0,  0, 0, 2'b00, 0, 0};

    #12;
    check_reset_values("reset");
    @(negedge clk);
    boot("b1");

    // Single-cycle RUN-state vectors; none of them leaves RUN.
    for (int i = 0; i < 7; i++) begin
      bus.exc_req_i          = vecs[i].exc_req;
      bus.data_req_pending_i = vecs[i].pending;
      bus.eret_insn_i        = vecs[i].eret;
      bus.id_valid_i         = vecs[i].id_valid;
      bus.dbg_halt_i         = vecs[i].dbg_halt;
      #2;
      check({vecs[i].name, "_ack"},     32'(bus.exc_ack_o),     32'(vecs[i].ack));
      check({vecs[i].name, "_save"},    32'(bus.save_epc_o),    32'(vecs[i].ack));
      check({vecs[i].name, "_pc_set"},  32'(bus.pc_set_o),      32'(vecs[i].pc_set));
      check({vecs[i].name, "_mux"},     32'(bus.pc_mux_o),      32'(vecs[i].mux));
      check({vecs[i].name, "_halt"},    32'(bus.halt_id_o),     32'(vecs[i].halt));
      check({vecs[i].name, "_restore"}, 32'(bus.csr_restore_o), 32'(vecs[i].restore));
      tick();
    end
    idle_inputs();
    tick();

    // Short drain: pending for the request cycle plus three DRAIN cycles, ack on DRAIN cycle 4.
    bus.exc_req_i          = 1'b1;
    bus.data_req_pending_i = 1'b1;
    #2;
    check("drain_req_halt", 32'(bus.halt_if_o), 32'd1);
    check("drain_req_ack",  32'(bus.exc_ack_o), 32'd0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      #2;
      check($sformatf("drain_c%0d_ack", c),  32'(bus.exc_ack_o), 32'd0);
      check($sformatf("drain_c%0d_halt", c), 32'(bus.halt_id_o), 32'd1);
      tick();
    end
    bus.data_req_pending_i = 1'b0;
    #2;
    check("drain_c4_ack",    32'(bus.exc_ack_o),  32'd1);
    check("drain_c4_save",   32'(bus.save_epc_o), 32'd1);
    check("drain_c4_pc_set", 32'(bus.pc_set_o),   32'd1);
    check("drain_c4_mux",    32'(bus.pc_mux_o),   32'd1);
    tick();
    idle_inputs();
    #2;
    check("drain_after_halt",    32'(bus.halt_if_o),       32'd0);
    check("drain_after_timeout", 32'(bus.drain_timeout_o), 32'd0);
    tick();

    // Timeout drain: pending never drops, ack forced on DRAIN cycle 16.
    bus.exc_req_i          = 1'b1;
    bus.data_req_pending_i = 1'b1;
    tick();
    ack_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      #2;
      if (bus.exc_ack_o === 1'b1) begin
        ack_cyc = c;
        check("to_timeout_before_edge", 32'(bus.drain_timeout_o), 32'd0);
        check("to_mux", 32'(bus.pc_mux_o), 32'd1);
        tick();
        break;
      end
      tick();
    end
    check("to_ack_cycle", 32'(ack_cyc), 32'd16);
    idle_inputs();
    #2;
    check("to_sticky_set", 32'(bus.drain_timeout_o), 32'd1);
    tick();
    tick();
    check("to_sticky_held", 32'(bus.drain_timeout_o), 32'd1);

    // Debug halt: request is not acked while halted, resume gives no pc_set.
    bus.dbg_halt_i = 1'b1;
    #2;
    check("dbg_enter_halt", 32'(bus.halt_if_o), 32'd1);
    check("dbg_enter_ack",  32'(bus.exc_ack_o), 32'd0);
    tick();
    bus.dbg_halt_i = 1'b0;
    bus.exc_req_i  = 1'b1;
    #2;
    check("dbg_halted_ack",  32'(bus.exc_ack_o), 32'd0);
    check("dbg_halted_halt", 32'(bus.halt_id_o), 32'd1);
    tick();
    bus.dbg_resume_i = 1'b1;
    #2;
    check("dbg_resume_pc_set", 32'(bus.pc_set_o),  32'd0);
    check("dbg_resume_ack",    32'(bus.exc_ack_o), 32'd0);
    tick();
    bus.dbg_resume_i = 1'b0;
    #2;
    check("dbg_after_ack", 32'(bus.exc_ack_o), 32'd1);
    tick();
    idle_inputs();
    tick();

    // dbg_halt_i during DRAIN is deferred until RUN.
    bus.exc_req_i          = 1'b1;
    bus.data_req_pending_i = 1'b1;
    tick();
    bus.dbg_halt_i = 1'b1;
    tick();
    bus.data_req_pending_i = 1'b0;
    #2;
    check("dd_ack", 32'(bus.exc_ack_o), 32'd1);
    tick();
    bus.exc_req_i = 1'b0;
    #2;
    check("dd_run_halt", 32'(bus.halt_if_o), 32'd1);
    tick();
    bus.dbg_halt_i = 1'b0;
    #2;
    check("dd_in_dbg_halt", 32'(bus.halt_if_o), 32'd1);
    bus.dbg_resume_i = 1'b1;
    tick();
    bus.dbg_resume_i = 1'b0;
    #2;
    check("dd_resumed", 32'(bus.halt_if_o), 32'd0);
    tick();

    // Reset asserted mid-DRAIN: everything returns to reset values, no ack.
    bus.exc_req_i          = 1'b1;
    bus.data_req_pending_i = 1'b1;
    tick();
    tick();
    #2;
    rst_n              = 1'b0;
    bus.fetch_enable_i = 1'b0;
    #1;
    check_reset_values("mid_drain_rst");
    tick();
    idle_inputs();
    #2;
    check("rst_held_ack", 32'(bus.exc_ack_o), 32'd0);
    @(negedge clk);

`ifdef RISCV_EXC_CNT_EN
    check("cnt_reset", 32'(exc_cnt), 32'd0);
    boot("b2");
    bus.exc_req_i = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    idle_inputs();
    check("cnt_saturate", 32'(exc_cnt), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
